// File: rtl/spi_shift_engine.sv
// spi_shift_engine: full-duplex WIDTH-bit serial shift engine with TX load handshake and RX holding buffer
module spi_shift_engine #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             peripheralClkEdgePos,
    input  logic             peripheralClkEdgeNeg,
    input  logic             abort,
    input  logic             loadValid,
    output logic             loadReady,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    output logic             serialDataOut,
    output logic             busy,
    output logic [CW-1:0]    bitCount,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             rxValid,
    input  logic             rxAck,
    output logic             overrun
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, nextState;
    logic [WIDTH-1:0] mem, shifted;
    logic sampledBit, rxBit, loadFire, abortFire, sampleEn, shiftEn, frameDone;
    assign loadFire  = (state == IDLE) & loadValid;
    assign abortFire = (state == SHIFT) & abort;
    assign sampleEn  = (state == SHIFT) & ~abort & peripheralClkEdgePos;
    assign shiftEn   = (state == SHIFT) & ~abort & peripheralClkEdgeNeg;
    assign frameDone = shiftEn & (bitCount == CW'(WIDTH - 1));
    // a simultaneous rising edge means the sample register is not yet updated
    assign rxBit     = peripheralClkEdgePos ? serialDataIn : sampledBit;
    assign shifted   = MSB_FIRST ? {mem[WIDTH-2:0], rxBit} : {rxBit, mem[WIDTH-1:1]};
    assign serialDataOut = MSB_FIRST ? mem[WIDTH-1] : mem[0];
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else state <= nextState;
    end
    always_comb begin
        nextState = state;
        if (loadFire) nextState = SHIFT;
        else if (abortFire | frameDone) nextState = IDLE;
    end
    always_comb begin
        loadReady = state == IDLE;
        busy      = state == SHIFT;
    end
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mem             <= '0;
            sampledBit      <= 1'b0;
            bitCount        <= '0;
            parallelDataOut <= '0;
            rxValid         <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            if (loadFire) begin
                mem      <= parallelDataIn;
                bitCount <= '0;
            end else if (shiftEn) begin
                mem      <= shifted;
                bitCount <= frameDone ? '0 : bitCount + CW'(1);
            end else if (abortFire) begin
                bitCount <= '0;
            end
            if (sampleEn) sampledBit <= serialDataIn;
            if (frameDone) parallelDataOut <= shifted;
            rxValid <= frameDone | (rxValid & ~rxAck);
            if (frameDone & rxValid & ~rxAck) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed and random frames on MSB-first and LSB-first engines against a word-level model
module tb_spi_shift_engine;
    logic clk = 1'b0;
    logic rstN, pos, neg, abort, loadValid, sdin, rxAck;
    logic [7:0] pdin;
    logic loadReadyA, sdoA, busyA, rxValidA, overrunA;
    logic loadReadyB, sdoB, busyB, rxValidB, overrunB;
    logic [3:0] bcA, bcB;
    logic [7:0] pdoA, pdoB;
    int checks = 0;
    int errors = 0;
    logic mValid, mOverrun;
    logic [7:0] expA, expB;

    always #5 clk = ~clk;

    spi_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b1)) dutA (
        .clk(clk), .rstN(rstN), .peripheralClkEdgePos(pos), .peripheralClkEdgeNeg(neg),
        .abort(abort), .loadValid(loadValid), .loadReady(loadReadyA), .parallelDataIn(pdin),
        .serialDataIn(sdin), .serialDataOut(sdoA), .busy(busyA), .bitCount(bcA),
        .parallelDataOut(pdoA), .rxValid(rxValidA), .rxAck(rxAck), .overrun(overrunA));

    spi_shift_engine #(.WIDTH(8), .MSB_FIRST(1'b0)) dutB (
        .clk(clk), .rstN(rstN), .peripheralClkEdgePos(pos), .peripheralClkEdgeNeg(neg),
        .abort(abort), .loadValid(loadValid), .loadReady(loadReadyB), .parallelDataIn(pdin),
        .serialDataIn(sdin), .serialDataOut(sdoB), .busy(busyB), .bitCount(bcB),
        .parallelDataOut(pdoB), .rxValid(rxValidB), .rxAck(rxAck), .overrun(overrunB));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkStatus(input string tag);
        chk({tag, " rxValidA"}, rxValidA, mValid);
        chk({tag, " rxValidB"}, rxValidB, mValid);
        chk({tag, " overrunA"}, overrunA, mOverrun);
        chk({tag, " overrunB"}, overrunB, mOverrun);
        chk({tag, " pdoA"}, pdoA, expA);
        chk({tag, " pdoB"}, pdoB, expB);
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, " busy"}, {busyA, busyB}, 2'b00);
        chk({tag, " loadReady"}, {loadReadyA, loadReadyB}, 2'b11);
        chk({tag, " bitCount"}, {bcA, bcB}, 8'h00);
    endtask

    // stream[k] is the k-th bit on the wire; abortAt<0 runs the full frame
    task automatic frame(input logic [7:0] tx, input logic [7:0] stream, input int abortAt,
                         input bit ackAtEnd, input bit bypass, input bit abortOnLoad);
        loadValid = 1'b1;
        abort = abortOnLoad;
        pdin = tx;
        tick();
        loadValid = 1'b0;
        abort = 1'b0;
        chk("load busy", {busyA, busyB, loadReadyA, loadReadyB}, 4'b1100);
        for (int k = 0; k < 8; k++) begin
            if (k == abortAt) begin
                abort = 1'b1;
                pos = 1'b1;
                neg = 1'b1;
                tick();
                abort = 1'b0;
                pos = 1'b0;
                neg = 1'b0;
                chkIdle("abort");
                chkStatus("abort");
                return;
            end
            chk("sdoA", sdoA, tx[7-k]);
            chk("sdoB", sdoB, tx[k]);
            chk("bitCount", {bcA, bcB}, {k[3:0], k[3:0]});
            if (bypass) begin
                pos = 1'b1;
                neg = 1'b1;
                sdin = stream[k];
            end else begin
                pos = 1'b1;
                sdin = stream[k];
                tick();
                pos = 1'b0;
                sdin = ~stream[k];
                neg = 1'b1;
            end
            if (k == 7) rxAck = ackAtEnd;
            tick();
            pos = 1'b0;
            neg = 1'b0;
            rxAck = 1'b0;
        end
        if (!ackAtEnd) mOverrun = mOverrun | mValid;
        mValid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            expA[7-k] = stream[k];
            expB[k] = stream[k];
        end
        chkIdle("done");
        chkStatus("done");
    endtask

    task automatic ack();
        rxAck = 1'b1;
        tick();
        rxAck = 1'b0;
        mValid = 1'b0;
        chkStatus("ack");
    endtask

    function automatic logic [7:0] rev(input logic [7:0] v);
        for (int i = 0; i < 8; i++) rev[i] = v[7-i];
    endfunction

    initial begin
        rstN = 1'b0;
        {pos, neg, abort, loadValid, sdin, rxAck} = '0;
        pdin = '0;
        mValid = 1'b0;
        mOverrun = 1'b0;
        expA = '0;
        expB = '0;
        #12;
        chkIdle("reset");
        chkStatus("reset");
        chk("reset sdo", {sdoA, sdoB}, 2'b00);
        @(negedge clk);
        rstN = 1'b1;
        tick();
        pos = 1'b1;
        neg = 1'b1;
        tick();
        pos = 1'b0;
        neg = 1'b0;
        chkIdle("idle edges");
        chk("idle sdo", {sdoA, sdoB}, 2'b00);
        // A5 out; 3C MSB-first on the wire lands as 3C in A
        frame(8'hA5, rev(8'h3C), -1, 1'b0, 1'b0, 1'b0);
        chk("3C msb", pdoA, 8'h3C);
        ack();
        // 3C LSB-first on the wire lands as 3C in B
        frame(8'hA5, 8'h3C, -1, 1'b0, 1'b0, 1'b0);
        chk("3C lsb", pdoB, 8'h3C);
        frame(8'h5A, 8'h81, -1, 1'b0, 1'b0, 1'b0);
        chk("overrun set", {overrunA, overrunB}, 2'b11);
        ack();
        frame(8'hF0, 8'h00, 3, 1'b0, 1'b0, 1'b0);
        frame(8'h0F, 8'hC3, -1, 1'b1, 1'b1, 1'b1);
        frame(8'h00, 8'hFF, -1, 1'b1, 1'b1, 1'b0);
        chk("bypass", {pdoA, pdoB}, 16'hFFFF);
        ack();
        for (int n = 0; n < 12; n++) begin
            frame(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                  1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 0) ack();
        end
        // asynchronous reset in the middle of a frame
        loadValid = 1'b1;
        pdin = 8'hFF;
        tick();
        loadValid = 1'b0;
        pos = 1'b1;
        neg = 1'b1;
        sdin = 1'b1;
        tick();
        tick();
        pos = 1'b0;
        neg = 1'b0;
        #2 rstN = 1'b0;
        #1;
        mValid = 1'b0;
        mOverrun = 1'b0;
        expA = '0;
        expB = '0;
        chkIdle("async reset");
        chkStatus("async reset");
        chk("async reset sdo", {sdoA, sdoB}, 2'b00);
        @(negedge clk);
        rstN = 1'b1;
        pos = 1'b1;
        neg = 1'b1;
        tick();
        tick();
        pos = 1'b0;
        neg = 1'b0;
        chkIdle("post reset");
        chkStatus("post reset");
        frame(8'h96, 8'h69, -1, 1'b0, 1'b0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
